// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pkg
//  Brief    : Shared defaults, instruction size and EX-stage state encoding
//             for the conditional-branch resolver.
//  Revision : 1.0  initial release
// ============================================================================
package branch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int INSN_BYTES = 4;

  // IDLE: no branch in EX.  PEND: a captured branch is waiting to resolve.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } br_state_e;

endpackage
`default_nettype wire

// File: rtl/branch_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : branch_sat_counter
//  Brief    : CNT_W-bit event counter that sticks at all-ones.
//  Revision : 1.0  initial release
// ============================================================================
module branch_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Advance on each enable until the all-ones ceiling is reached
  always_comb begin
    count_d = count_q;
    if (en_i && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter state, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolver
//  Brief    : EX-stage resolver for beq. Captures the ID-stage prediction,
//             compares the forwarded operands one cycle later, pulses the
//             predictor update and squashes/redirects fetch on a mispredict.
//  Config   : define BRANCH_STATS_EN to add resolved/mispredict counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolver
  import branch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef BRANCH_STATS_EN
  ,parameter int CNT_W = 32
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              id_branch_i,
  input  logic              id_predict_i,
  input  logic [ADDR_W-1:0] id_pc_i,
  input  logic [ADDR_W-1:0] id_target_i,
  input  logic [DATA_W-1:0] ex_rs1_i,
  input  logic [DATA_W-1:0] ex_rs2_i,
  output logic              update_o,
  output logic              result_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,output logic [CNT_W-1:0] stat_branches_o
  ,output logic [CNT_W-1:0] stat_mispred_o
`endif
);

  br_state_e         state_q, state_d;
  logic              ex_pred_q, ex_pred_d;
  logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
  logic [ADDR_W-1:0] ex_tgt_q, ex_tgt_d;
  logic              capture;
  logic              taken;

  // State and EX-stage branch registers; reset drops any pending branch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ex_pred_q <= 1'b0;
      ex_pc_q   <= '0;
      ex_tgt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ex_pred_q <= ex_pred_d;
      ex_pc_q   <= ex_pc_d;
      ex_tgt_q  <= ex_tgt_d;
    end
  end

  // Next state: a wrong-path ID branch (flush this cycle) is never captured,
  // and a capture in the resolve cycle keeps EX occupied for back-to-back use
  always_comb begin
    capture   = id_branch_i & ~stall_i & ~flush_o;
    state_d   = state_q;
    ex_pred_d = ex_pred_q;
    ex_pc_d   = ex_pc_q;
    ex_tgt_d  = ex_tgt_q;
    case (state_q)
      IDLE:    if (capture) state_d = PEND;
      PEND: begin
        if (capture)       state_d = PEND;
        else if (update_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      ex_pred_d = id_predict_i;
      ex_pc_d   = id_pc_i;
      ex_tgt_d  = id_target_i;
    end
  end

  // Resolution outputs; a stall holds everything at zero so the predictor
  // sees exactly one update per branch
  always_comb begin
    taken         = (ex_rs1_i == ex_rs2_i);
    update_o      = (state_q == PEND) & ~stall_i;
    result_o      = update_o & taken;
    flush_o       = update_o & (taken != ex_pred_q);
    redirect_pc_o = '0;
    if (flush_o) begin
      redirect_pc_o = taken ? ex_tgt_q : (ex_pc_q + ADDR_W'(INSN_BYTES));
    end
  end

`ifdef BRANCH_STATS_EN
  branch_sat_counter #(.CNT_W(CNT_W)) u_stat_branches (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (update_o),
    .value_o (stat_branches_o)
  );

  branch_sat_counter #(.CNT_W(CNT_W)) u_stat_mispred (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (flush_o),
    .value_o (stat_mispred_o)
  );
`endif

endmodule
`default_nettype wire
